// File: rtl/intercal_unalu_pkg.sv
// intercal_unalu_pkg: shared types, constants and helpers for the inverse-ALU engine
package intercal_unalu_pkg;
    localparam int WORD_W = 32;
    localparam int STEP_LIST [6] = '{1, 2, 4, 8, 16, 32};
    typedef enum logic [1:0] {UNMINGLE = 2'd0, DEPOSIT16 = 2'd1, DEPOSIT32 = 2'd2, RSVD = 2'd3} op_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    function automatic bit step_legal(input int s);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) ok = ok | (STEP_LIST[i] == s);
        return ok;
    endfunction
    // odd bits to the upper half, even bits to the lower half
    function automatic logic [WORD_W-1:0] unmingle(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] u;
        for (int i = 0; i < WORD_W / 2; i++) begin
            u[WORD_W/2 + i] = w[2*i + 1];
            u[i] = w[2*i];
        end
        return u;
    endfunction
endpackage

// File: rtl/intercal_unalu_if.sv
// intercal_unalu_if: request/response handshake bundle of the inverse-ALU engine
interface intercal_unalu_if;
    logic in_valid;
    logic in_ready;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic out_valid;
    logic out_ready;
    logic [31:0] f;
    logic [5:0] cnt;
    logic err;
    modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, f, cnt, err);
    modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, f, cnt, err);
endinterface

// File: rtl/intercal_deposit_slice.sv
// intercal_deposit_slice: deposits compressed bits into STEP mask positions, advancing lane pointers
module intercal_deposit_slice #(
    parameter int STEP = 1
) (
    input  logic [4:0]      idx,
    input  logic [STEP-1:0] m_bits,
    input  logic [5:0]      ptr_lo,
    input  logic [4:0]      ptr_hi,
    input  logic [31:0]     v,
    input  logic            lane16,
    output logic [STEP-1:0] r_bits,
    output logic [5:0]      ptr_lo_nx,
    output logic [4:0]      ptr_hi_nx
);
    always_comb begin
        ptr_lo_nx = ptr_lo;
        ptr_hi_nx = ptr_hi;
        r_bits = '0;
        for (int i = 0; i < STEP; i++) begin
            if (m_bits[i]) begin
                // upper lane of a DEPOSIT16 draws from v[31:16]
                if (lane16 && (int'(idx) + i) >= 16) begin
                    r_bits[i] = v[{1'b1, ptr_hi_nx[3:0]}];
                    ptr_hi_nx = ptr_hi_nx + 5'd1;
                end else begin
                    r_bits[i] = v[ptr_lo_nx[4:0]];
                    ptr_lo_nx = ptr_lo_nx + 6'd1;
                end
            end
        end
    end
endmodule

// File: rtl/intercal_unalu.sv
// intercal_unalu: iterative unmingle/deposit engine; INTERCAL_UNALU_EARLY_EXIT_EN enables early exit
module intercal_unalu
    import intercal_unalu_pkg::*;
#(
    parameter int STEP = 1
) (
    input logic clk,
    input logic rst_n,
    intercal_unalu_if.slave bus
);
    if (!step_legal(STEP)) begin : g_bad_step
        $error("intercal_unalu: STEP must be 1, 2, 4, 8, 16 or 32");
    end
    state_e state;
    op_e op_q, req_op;
    logic [31:0] v_q, m_q, r, r_nx;
    logic [5:0] idx, idx_nx, ptr_lo, lo_nx;
    logic [4:0] ptr_hi, hi_nx;
    logic [STEP-1:0] m_bits, r_bits;
    logic fin, zero_exit;
    assign req_op = op_e'(bus.op);
    assign m_bits = m_q[idx[4:0] +: STEP];
    assign idx_nx = idx + 6'(STEP);
`ifdef INTERCAL_UNALU_EARLY_EXIT_EN
    assign fin = (m_q >> idx_nx) == 32'd0;
    assign zero_exit = bus.b == 32'd0;
`else
    assign fin = idx_nx[5];
    assign zero_exit = 1'b0;
`endif
    intercal_deposit_slice #(.STEP(STEP)) u_slice (
        .idx(idx[4:0]),
        .m_bits(m_bits),
        .ptr_lo(ptr_lo),
        .ptr_hi(ptr_hi),
        .v(v_q),
        .lane16(op_q == DEPOSIT16),
        .r_bits(r_bits),
        .ptr_lo_nx(lo_nx),
        .ptr_hi_nx(hi_nx)
    );
    always_comb begin
        r_nx = r;
        r_nx[idx[4:0] +: STEP] = r_bits;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q <= UNMINGLE;
            v_q <= '0;
            m_q <= '0;
            r <= '0;
            idx <= '0;
            ptr_lo <= '0;
            ptr_hi <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.f <= '0;
            bus.cnt <= '0;
            bus.err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q <= req_op;
                    v_q <= bus.a;
                    m_q <= bus.b;
                    r <= '0;
                    idx <= '0;
                    ptr_lo <= '0;
                    ptr_hi <= '0;
                    bus.in_ready <= 1'b0;
                    if (req_op == UNMINGLE || req_op == RSVD || zero_exit) begin
                        state <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.f <= req_op == UNMINGLE ? unmingle(bus.a) : '0;
                        bus.cnt <= '0;
                        bus.err <= req_op == RSVD;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    r <= r_nx;
                    idx <= idx_nx;
                    ptr_lo <= lo_nx;
                    ptr_hi <= hi_nx;
                    if (fin) begin
                        state <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.f <= r_nx;
                        bus.cnt <= lo_nx + {1'b0, hi_nx};
                    end
                end
                DONE: if (bus.out_ready) begin
                    state <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                    bus.err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
